// File: rtl/iob_vga_pkg.sv
// Shared definitions for the VGA frame-buffer pixel fetch stage.
package iob_vga_pkg;

    localparam int unsigned PIX_W     = 16;
    localparam int unsigned WORD_W    = 32;

    // RGB444 field positions inside a 16-bit pixel
    localparam int unsigned RGB_CH_W  = 4;
    localparam int unsigned RGB_B_LSB = 0;
    localparam int unsigned RGB_G_LSB = 4;
    localparam int unsigned RGB_R_LSB = 8;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;

    // Two pixels are packed per 32-bit memory word
    function automatic int unsigned words_per_frame(input int unsigned h, input int unsigned v);
        return (h * v) / 2;
    endfunction

    localparam int unsigned WORDS_PER_FRAME = words_per_frame(H_RES_DEF, V_RES_DEF);

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/iob_vga_pixel_fetch_if.sv
// IOb native read channel between the fetch stage and frame memory.
interface iob_vga_pixel_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output valid, output addr, input rdata, input ready);
    modport slave  (input valid, input addr, output rdata, output ready);
endinterface

// File: rtl/iob_vga_pixel_fifo.sv
// First-word-fall-through FIFO with synchronous flush.
module iob_vga_pixel_fifo #(
    parameter int unsigned AW = 5,
    parameter int unsigned W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy tracking; flush wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign count = cnt_q;

endmodule

// File: rtl/iob_vga_pixel_fetch.sv
// Frame-buffer fetch: IOb word reads -> FWFT FIFO -> one 16-bit pixel per strobe.
module iob_vga_pixel_fetch
    import iob_vga_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned FIFO_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    fb_base,
    input  logic                 frame_start,
    iob_vga_pixel_fetch_if.master m,
    input  logic                 pixel_rd,
    output logic [PIX_W-1:0]     pixel,
    output logic                 pixel_valid,
    output logic                 underrun
);
    localparam int unsigned WORDS = words_per_frame(H_RES, V_RES);
    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned OCC_W = FIFO_AW + 2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [CNT_W-1:0]  wcnt_q,  wcnt_d;
    logic              valid_q, valid_d;
    logic              half_q;
    logic              underrun_q;

    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [OCC_W-1:0]  occ_after;
    logic              last_word;

    // Second pixel of the head word consumed -> retire the word
    assign pop = pixel_rd && !fifo_empty && half_q && !frame_start;

    // Occupancy once the word accepted this cycle lands, for back-to-back requests
    assign occ_after = OCC_W'(fifo_count) + OCC_W'(1) - OCC_W'(pop);
    assign last_word = ((wcnt_q + CNT_W'(1)) == CNT_W'(WORDS));

    iob_vga_pixel_fifo #(
        .AW (FIFO_AW),
        .W  (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (push),
        .wdata (m.rdata),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Fetch FSM state and request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and request logic; frame_start overrides every state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q;
        push    = 1'b0;

        if (frame_start) begin
            base_d = fb_base;
            wcnt_d = '0;
            if (valid_q && !m.ready) begin
                // Outstanding request must complete before restarting
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
                valid_d = 1'b0;
                addr_d  = fb_base;
            end
        end else begin
            case (state_q)
                ST_IDLE: valid_d = 1'b0;
                ST_FETCH: begin
                    if (valid_q) begin
                        if (m.ready) begin
                            push   = 1'b1;
                            addr_d = addr_q + ADDR_W'(4);
                            wcnt_d = wcnt_q + CNT_W'(1);
                            if (last_word) begin
                                state_d = ST_DONE;
                                valid_d = 1'b0;
                            end else begin
                                valid_d = enable && (occ_after < OCC_W'(DEPTH));
                            end
                        end
                    end else begin
                        valid_d = enable && !fifo_full;
                    end
                end
                ST_DRAIN: begin
                    if (m.ready) begin
                        state_d = ST_FETCH;
                        valid_d = 1'b0;
                        addr_d  = base_q;
                    end
                end
                ST_DONE: valid_d = 1'b0;
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Half-word select and sticky underrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (frame_start) begin
            half_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (pixel_rd) begin
            if (!fifo_empty) half_q <= ~half_q;
            else             underrun_q <= 1'b1;
        end
    end

    assign m.valid     = valid_q;
    assign m.addr      = addr_q;
    assign pixel_valid = !fifo_empty;
    assign underrun    = underrun_q;
    assign pixel       = fifo_empty ? '0
                       : (half_q ? head[2*PIX_W-1:PIX_W] : head[PIX_W-1:0]);

endmodule

// File: tb/tb_iob_vga_pixel_fetch.sv
// Self-checking bench for iob_vga_pixel_fetch with a pixel scoreboard.
module tb_iob_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] fb_base;
    logic        frame_start;
    logic        pixel_rd;
    logic [15:0] pixel, pixel_s;
    logic        pixel_valid, pixel_valid_s;
    logic        underrun, underrun_s;

    iob_vga_pixel_fetch_if #(.ADDR_W(32)) bus ();
    iob_vga_pixel_fetch_if #(.ADDR_W(32)) bus_s ();

    iob_vga_pixel_fetch #(.ADDR_W(32), .H_RES(640), .V_RES(480), .FIFO_AW(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fb_base(fb_base),
        .frame_start(frame_start), .m(bus), .pixel_rd(pixel_rd),
        .pixel(pixel), .pixel_valid(pixel_valid), .underrun(underrun)
    );

    iob_vga_pixel_fetch #(.ADDR_W(32), .H_RES(4), .V_RES(2), .FIFO_AW(5)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .fb_base(fb_base),
        .frame_start(frame_start), .m(bus_s), .pixel_rd(pixel_rd),
        .pixel(pixel_s), .pixel_valid(pixel_valid_s), .underrun(underrun_s)
    );

    always #20 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] pq[$];
    logic [31:0] acc_q[$];
    bit          hold = 1'b0;
    int          lat = 0;
    int          wait_cnt = 0;
    bit          drain = 1'b0;
    bit          exp_under = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          ovr_once = 1'b0;
    logic [31:0] ovr_data = '0;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // One clock of the main DUT: protocol checks, consumer, memory responder, scoreboard
    task automatic step(input bit rd, input bit fs);
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        checks++;
        if (prev_valid && !prev_ready && (bus.valid !== 1'b1 || bus.addr !== prev_addr)) begin
            errors++;
            $display("FAIL req_hold cyc %0d valid %b addr %h expected valid 1 addr %h", cyc, bus.valid, bus.addr, prev_addr);
        end
        checks++;
        if (pixel_valid !== (pq.size() != 0)) begin
            errors++;
            $display("FAIL pixel_valid cyc %0d got %b expected %b", cyc, pixel_valid, pq.size() != 0);
        end
        checks++;
        if (underrun !== exp_under) begin
            errors++;
            $display("FAIL underrun cyc %0d got %b expected %b", cyc, underrun, exp_under);
        end
        if (pixel_valid !== 1'b1) begin
            checks++;
            if (pixel !== 16'h0000) begin
                errors++;
                $display("FAIL pixel_idle cyc %0d got %h expected 0000", cyc, pixel);
            end
        end
        pixel_rd    = rd;
        frame_start = fs;
        if (rd && !fs) begin
            if (pixel_valid === 1'b1) begin
                if (pq.size() != 0) begin
                    e = pq.pop_front();
                    checks++;
                    if (pixel !== e) begin
                        errors++;
                        $display("FAIL pixel_data cyc %0d got %h expected %h", cyc, pixel, e);
                    end
                end
            end else begin
                exp_under = 1'b1;
            end
        end
        bus.ready = 1'b0;
        if (bus.valid === 1'b1 && !hold) begin
            if (wait_cnt >= lat) begin
                bus.ready = 1'b1;
                bus.rdata = ovr_once ? ovr_data : mk(bus.addr);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
        if (fs) begin
            exp_under = 1'b0;
            pq.delete();
            drain = (bus.valid === 1'b1) && !bus.ready;
        end else if (bus.ready) begin
            if (drain) begin
                drain = 1'b0;
            end else begin
                pq.push_back(bus.rdata[15:0]);
                pq.push_back(bus.rdata[31:16]);
                acc_q.push_back(bus.addr);
                ovr_once = 1'b0;
            end
        end
        prev_valid = (bus.valid === 1'b1);
        prev_ready = bus.ready;
        prev_addr  = bus.addr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b1;
        fb_base = '0;
        frame_start = 1'b0;
        pixel_rd = 1'b0;
        bus.ready = 1'b0;   bus.rdata = '0;
        bus_s.ready = 1'b0; bus_s.rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0;
        pq.delete(); acc_q.delete();
        exp_under = 1'b0; drain = 1'b0; wait_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 6;
        if (bus.valid !== 1'b0)     begin errors++; $display("FAIL rst_valid got %b expected 0", bus.valid); end
        if (bus.addr !== 32'h0)     begin errors++; $display("FAIL rst_addr got %h expected 0", bus.addr); end
        if (pixel !== 16'h0)        begin errors++; $display("FAIL rst_pixel got %h expected 0", pixel); end
        if (pixel_valid !== 1'b0)   begin errors++; $display("FAIL rst_pixel_valid got %b expected 0", pixel_valid); end
        if (underrun !== 1'b0)      begin errors++; $display("FAIL rst_underrun got %b expected 0", underrun); end
        if (bus_s.valid !== 1'b0)   begin errors++; $display("FAIL rst_valid_s got %b expected 0", bus_s.valid); end
    endtask

    task automatic test_first_fetch();
        int first_acc = -1;
        int first_pv  = -1;
        hold = 1'b0; lat = 2; acc_q.delete();
        fb_base = 32'h1000;
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (first_pv < 0 && pixel_valid === 1'b1) first_pv = cyc;
            if (first_acc < 0 && acc_q.size() > 0) first_acc = cyc;
        end
        checks += 4;
        if (acc_q.size() < 3) begin
            errors += 3;
            $display("FAIL first_addrs got %0d requests expected at least 3", acc_q.size());
        end else begin
            if (acc_q[0] !== 32'h1000) begin errors++; $display("FAIL addr0 got %h expected 00001000", acc_q[0]); end
            if (acc_q[1] !== 32'h1004) begin errors++; $display("FAIL addr1 got %h expected 00001004", acc_q[1]); end
            if (acc_q[2] !== 32'h1008) begin errors++; $display("FAIL addr2 got %h expected 00001008", acc_q[2]); end
        end
        if (first_acc < 0 || first_pv != first_acc + 1) begin
            errors++;
            $display("FAIL pv_latency got cycle %0d expected %0d", first_pv, first_acc + 1);
        end
    endtask

    task automatic test_pixel_split();
        hold = 1'b0; lat = 0;
        ovr_once = 1'b1; ovr_data = 32'hABCD_0123;
        fb_base = 32'h2000;
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        checks++;
        if (pixel !== 16'h0123) begin errors++; $display("FAIL split_p0 got %h expected 0123", pixel); end
        step(1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (pixel !== 16'hABCD) begin errors++; $display("FAIL split_p1 got %h expected abcd", pixel); end
        step(1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (pixel !== 16'h2004) begin errors++; $display("FAIL split_pop got %h expected 2004", pixel); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_fill();
        hold = 1'b0; lat = 0;
        fb_base = 32'h3000;
        step(1'b0, 1'b1);
        acc_q.delete();
        repeat (80) step(1'b0, 1'b0);
        checks += 2;
        if (acc_q.size() != 32) begin errors++; $display("FAIL fill_count got %0d expected 32", acc_q.size()); end
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL fill_valid got %b expected 0", bus.valid); end
        acc_q.delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        checks += 2;
        if (acc_q.size() != 1) begin
            errors++;
            $display("FAIL refill_count got %0d expected 1", acc_q.size());
        end else if (acc_q[0] !== 32'h3080) begin
            errors++;
            $display("FAIL refill_addr got %h expected 00003080", acc_q[0]);
        end
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL refill_valid got %b expected 0", bus.valid); end
    endtask

    task automatic test_drain();
        logic [31:0] a;
        int n;
        hold = 1'b1; lat = 0;
        fb_base = 32'h4000;
        step(1'b0, 1'b1);
        n = 0;
        while (bus.valid !== 1'b1 && n < 10) begin step(1'b0, 1'b0); n++; end
        checks++;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL drain_req timeout valid %b expected 1", bus.valid); end
        a = bus.addr;
        fb_base = 32'h8000;
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (bus.valid !== 1'b1 || bus.addr !== a) begin
                errors++;
                $display("FAIL drain_hold valid %b addr %h expected 1 %h", bus.valid, bus.addr, a);
            end
        end
        hold = 1'b0;
        acc_q.delete();
        step(1'b0, 1'b0);
        @(posedge clk); #1;
        checks += 3;
        if (pixel_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b expected 0", pixel_valid); end
        if (underrun !== 1'b0)    begin errors++; $display("FAIL drain_underrun got %b expected 0", underrun); end
        if (bus.valid !== 1'b0)   begin errors++; $display("FAIL drain_release got %b expected 0", bus.valid); end
        n = 0;
        while (acc_q.size() == 0 && n < 10) begin step(1'b0, 1'b0); n++; end
        checks++;
        if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL drain_next timeout got no request expected 00008000");
        end else if (acc_q[0] !== 32'h8000) begin
            errors++;
            $display("FAIL drain_next got %h expected 00008000", acc_q[0]);
        end
    endtask

    task automatic test_underrun();
        hold = 1'b1;
        fb_base = 32'h5000;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks += 2;
        if (pixel_valid !== 1'b0) begin errors++; $display("FAIL ur_empty got %b expected 0", pixel_valid); end
        if (pixel !== 16'h0)      begin errors++; $display("FAIL ur_pixel got %h expected 0000", pixel); end
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        checks += 2;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b expected 1", underrun); end
        if (pixel !== 16'h0)   begin errors++; $display("FAIL ur_pixel2 got %h expected 0000", pixel); end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %b expected 0", underrun); end
        hold = 1'b0;
    endtask

    task automatic test_back_to_back();
        hold = 1'b0; lat = 1;
        fb_base = 32'h6000;
        step(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b0);
        lat = 0;
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 3) != 0), 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_small_frame();
        logic [15:0] sq[$];
        logic [15:0] e;
        int nreq = 0;
        int npix = 0;
        bit rd;
        do_reset();
        fb_base = 32'h0100;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (pixel_valid_s !== (sq.size() != 0)) begin
                errors++;
                $display("FAIL small_pv cyc %0d got %b expected %b", i, pixel_valid_s, sq.size() != 0);
            end
            rd = (i % 3) != 0;
            pixel_rd = rd;
            if (rd && pixel_valid_s === 1'b1 && sq.size() != 0) begin
                e = sq.pop_front();
                npix++;
                checks++;
                if (pixel_s !== e) begin
                    errors++;
                    $display("FAIL small_pixel cyc %0d got %h expected %h", i, pixel_s, e);
                end
            end
            bus_s.ready = (bus_s.valid === 1'b1);
            if (bus_s.ready) begin
                bus_s.rdata = mk(bus_s.addr);
                checks++;
                if (bus_s.addr !== 32'h0100 + 32'(4 * nreq)) begin
                    errors++;
                    $display("FAIL small_addr got %h expected %h", bus_s.addr, 32'h0100 + 32'(4 * nreq));
                end
                nreq++;
                sq.push_back(bus_s.rdata[15:0]);
                sq.push_back(bus_s.rdata[31:16]);
            end
        end
        pixel_rd = 1'b0;
        bus_s.ready = 1'b0;
        @(negedge clk);
        checks += 3;
        if (nreq != 4)            begin errors++; $display("FAIL small_reqs got %0d expected 4", nreq); end
        if (npix != 8)            begin errors++; $display("FAIL small_pixels got %0d expected 8", npix); end
        if (bus_s.valid !== 1'b0) begin errors++; $display("FAIL small_done got %b expected 0", bus_s.valid); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_pixel_split();
        test_fill();
        test_drain();
        test_underrun();
        test_back_to_back();
        test_small_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_vga_pixel_fetch.md
Name: iob_vga_pixel_fetch

Overview:
Frame-buffer fetch stage directly upstream of the VGA timing/colour generator. Reads 32-bit words from frame memory over the IOb native master interface, buffers them in a first-word-fall-through FIFO, and presents one 16-bit pixel (RGB444 in [11:0]) per consumer strobe. Decouples memory latency from the 25 MHz pixel cadence; the consumer issues one pixel_rd per visible pixel.

Parameters:
ADDR_W, 32, memory byte-address width
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
FIFO_AW, 5, log2 of FIFO depth in 32-bit words (default depth 32)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = new memory requests allowed
fb_base  in  ADDR_W  frame-buffer byte base address, word aligned, sampled on frame_start
frame_start  in  1  one-cycle pulse: restart fetch at fb_base, flush buffered data
m_valid  out  1  IOb request valid
m_addr  out  ADDR_W  IOb request byte address
m_rdata  in  32  IOb read data, valid when m_ready=1
m_ready  in  1  IOb request accepted and data returned
pixel_rd  in  1  consume current pixel
pixel  out  16  current pixel; 16'h0000 when pixel_valid=0
pixel_valid  out  1  a pixel is available
underrun  out  1  sticky: pixel_rd seen while pixel_valid=0

Behaviour:
- Reset values: m_valid 0, m_addr 0, pixel 0, pixel_valid 0, underrun 0, FSM IDLE, FIFO empty, half-select 0, word counter 0.
- Frame size: WORDS = H_RES*V_RES/2 (153600 at defaults); two pixels per word, pixel0 = word[15:0], pixel1 = word[31:16].
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: m_valid=0; frame_start -> FETCH with addr=fb_base, word count 0.
  - FETCH: m_valid=1 when enable=1 and FIFO count < depth; once m_valid is asserted it holds, with m_addr stable, until m_ready. On m_ready: push m_rdata, addr += 4, count += 1; if count reaches WORDS -> DONE, else stay in FETCH and may re-assert m_valid the next cycle (at most one request outstanding).
  - DONE: m_valid=0; waits for frame_start.
  - DRAIN: entered when frame_start arrives while m_valid=1 and m_ready=0; keeps m_valid/m_addr until m_ready, discards that m_rdata, then -> FETCH at the base latched at the frame_start.
- frame_start (any state): FIFO flushed, half-select 0, underrun cleared, fb_base latched, word count 0 in the same cycle. If m_ready coincides with frame_start, the returned data is discarded and the FSM goes straight to FETCH.
- enable=0: no new request is raised. An asserted m_valid is never withdrawn before m_ready.
- FIFO is FWFT: a word accepted on cycle N gives pixel_valid=1 on cycle N+1. Simultaneous push and pop in one cycle is legal, including when full (pop frees the slot) and when count=1.
- pixel = selected half of the FIFO head (combinational); pixel_valid = FIFO not empty.
- pixel_rd with pixel_valid=1: if half=0, set half=1; if half=1, pop and set half=0.
- pixel_rd with pixel_valid=0: set underrun=1; no pointer change.
- Full FIFO: no request issued; only the count value gates requests.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package iob_vga_pkg: FSM state encoding, PIX_W=16, RGB444 field positions, WORDS_PER_FRAME derived from H_RES/V_RES.
- Sub-module iob_vga_pixel_fifo: synchronous FWFT FIFO (32-bit wide, 2^FIFO_AW deep) with flush, full, empty and count outputs.

Test Plan:
- Reset, then frame_start with fb_base=0x1000 and m_ready returning after 2 cycles -> first m_addr=0x1000, then 0x1004 and 0x1008; pixel_valid rises 1 cycle after the first m_ready.
- m_rdata=0xABCD_0123 followed by two pixel_rd strobes -> pixel reads 0x0123, then 0xABCD, then the FIFO pops.
- No pixel_rd and m_ready always 1 -> exactly 32 words accepted, then m_valid=0. One pixel_rd pair -> one new request.
- frame_start while m_valid=1 and m_ready held low for 5 cycles -> m_valid/m_addr stay stable; data returned is discarded; the next request is at the new fb_base; FIFO empty; underrun=0.
- pixel_rd on an empty FIFO -> underrun=1 and pixel=0; underrun stays 1 until the next frame_start.
- Reduced-size frame (H_RES=4, V_RES=2) -> exactly 4 requests, then DONE with m_valid=0; the 8 pixels are delivered in order.
